// File: rtl/day_of_year_decoder_if.sv
// Start/done handshake bundle for the day-of-year decoder: request fields in,
// result fields and status out.
interface day_of_year_decoder_if;
  logic       start;
  logic [8:0] dayOfYear;
  logic       leapYear;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] month;
  logic [5:0] dayOfMonth;

  modport master (
    output start, dayOfYear, leapYear,
    input  busy, done, error, month, dayOfMonth
  );

  modport slave (
    input  start, dayOfYear, leapYear,
    output busy, done, error, month, dayOfMonth
  );
endinterface

// File: rtl/day_of_year_decoder.sv
// Converts a day-of-year number into month/day-of-month by walking the month
// lengths one month per clock, subtracting each full month from the remainder.
module day_of_year_decoder (
  input  logic                  clk,
  input  logic                  reset,
  day_of_year_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [8:0] rem;
  logic [3:0] mon;
  logic       leap;

  logic [3:0] month_q;
  logic [5:0] day_q;
  logic       error_q;

  logic [8:0] len;
  logic [8:0] year_len;
  logic       in_range;
  logic       fits;
  logic       overrun;
  logic       busy_c;
  logic       done_c;

  function automatic logic [8:0] month_len(input logic [3:0] m, input logic lp);
    logic [8:0] l;
    case (m)
      4'd2:                    l = lp ? 9'd29 : 9'd28;
      4'd4, 4'd6, 4'd9, 4'd11: l = 9'd30;
      default:                 l = 9'd31;
    endcase
    return l;
  endfunction

  always_comb begin
    len      = month_len(mon, leap);
    year_len = 9'd365 + {8'd0, bus.leapYear};
    in_range = (bus.dayOfYear != 9'd0) && (bus.dayOfYear <= year_len);
    fits     = (rem <= len);
    // Unreachable for validated input; guards against walking past December.
    overrun  = (mon == 4'd12) && !fits;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = in_range ? CALC : DONE;
        end
      end
      CALC: begin
        if (fits || overrun) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CALC: busy_c = 1'b1;
      DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
        done_c = 1'b0;
      end
    endcase
  end

  // Remainder walk and result registers; results hold until the next accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= 9'd0;
      mon     <= 4'd0;
      leap    <= 1'b0;
      month_q <= 4'd0;
      day_q   <= 6'd0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem     <= bus.dayOfYear;
            mon     <= 4'd1;
            leap    <= bus.leapYear;
            month_q <= 4'd0;
            day_q   <= 6'd0;
            error_q <= !in_range;
          end
        end
        CALC: begin
          if (fits) begin
            month_q <= mon;
            day_q   <= rem[5:0];
          end else if (overrun) begin
            month_q <= 4'd0;
            day_q   <= 6'd0;
            error_q <= 1'b1;
          end else begin
            rem <= rem - len;
            mon <= mon + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.error      = error_q;
  assign bus.month      = month_q;
  assign bus.dayOfMonth = day_q;

endmodule

// File: tb/tb_day_of_year_decoder.sv
// Bench for day_of_year_decoder: calendar-table reference model checked every
// cycle, directed vectors with literal expectations, and a full round-trip sweep.
module tb_day_of_year_decoder;

  logic clk;
  logic reset;

  day_of_year_decoder_if dut_if ();

  day_of_year_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Calendar helpers
  function automatic int mlen(input int m, input bit lp);
    case (m)
      2:           return lp ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic int days_before(input int m, input bit lp);
    int s = 0;
    for (int i = 1; i < m; i++) s += mlen(i, lp);
    return s;
  endfunction

  typedef struct packed {
    logic [3:0] m;
    logic [5:0] d;
    logic       e;
  } res_t;

  // Pick the month whose cumulative range contains the day number.
  function automatic res_t decode(input int doy, input bit lp);
    res_t r;
    r = '0;
    if (doy < 1 || doy > 365 + int'(lp)) begin
      r.e = 1'b1;
    end else begin
      for (int m = 12; m >= 1; m--) begin
        if (r.m == 4'd0 && doy > days_before(m, lp)) begin
          r.m = 4'(m);
          r.d = 6'(doy - days_before(m, lp));
        end
      end
    end
    return r;
  endfunction

  // Reference model: k counts cycles since acceptance, L is the result latency.
  int   m_k = 0;
  int   m_L = 0;
  bit   m_ok = 1'b0;
  res_t m_res;
  res_t m_out;

  always @(posedge clk) begin
    res_t r;
    if (reset) begin
      m_k   <= 0;
      m_out <= '0;
      m_ok  <= 1'b1;
    end else if (m_k == 0) begin
      if (dut_if.start) begin
        r     = decode(int'(dut_if.dayOfYear), dut_if.leapYear);
        m_res <= r;
        m_L   <= r.e ? 1 : int'(r.m) + 1;
        m_k   <= 1;
        m_out <= r.e ? r : '0;
      end
    end else if (m_k == m_L) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_L) m_out <= m_res;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_busy", int'(dut_if.busy), int'(m_k != 0));
      chk("model_done", int'(dut_if.done), int'(m_k != 0 && m_k == m_L));
      chk("model_error", int'(dut_if.error), int'(m_out.e));
      chk("model_month", int'(dut_if.month), int'(m_out.m));
      chk("model_day", int'(dut_if.dayOfMonth), int'(m_out.d));
    end
  end

  // Leaves the bench at the first negedge after the accepting edge.
  task automatic launch(input int doy, input bit lp);
    @(negedge clk);
    dut_if.start     = 1'b1;
    dut_if.dayOfYear = 9'(doy);
    dut_if.leapYear  = lp;
    @(negedge clk);
    dut_if.start = 1'b0;
  endtask

  task automatic finish(input int em, input int ed, input int ee, input int elat, input int n0);
    int n = n0;
    while (!dut_if.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, elat);
    chk("month", int'(dut_if.month), em);
    chk("day", int'(dut_if.dayOfMonth), ed);
    chk("error", int'(dut_if.error), ee);
    @(negedge clk);
    chk("done_falls", int'(dut_if.done), 0);
    chk("busy_falls", int'(dut_if.busy), 0);
    chk("month_hold", int'(dut_if.month), em);
    chk("day_hold", int'(dut_if.dayOfMonth), ed);
  endtask

  task automatic run(input int doy, input bit lp, input int em, input int ed, input int ee, input int elat);
    launch(doy, lp);
    finish(em, ed, ee, elat, 1);
  endtask

  initial begin
    int pulses;
    reset            = 1'b1;
    dut_if.start     = 1'b0;
    dut_if.dayOfYear = 9'd0;
    dut_if.leapYear  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(dut_if.busy), 0);
    chk("rst_done", int'(dut_if.done), 0);
    chk("rst_error", int'(dut_if.error), 0);
    chk("rst_month", int'(dut_if.month), 0);
    chk("rst_day", int'(dut_if.dayOfMonth), 0);
    reset = 1'b0;

    run(32, 0, 2, 1, 0, 3);
    run(1, 0, 1, 1, 0, 2);
    run(365, 0, 12, 31, 0, 13);
    run(0, 0, 0, 0, 1, 1);
    run(366, 0, 0, 0, 1, 1);
    run(60, 1, 2, 29, 0, 3);
    run(60, 0, 3, 1, 0, 4);
    run(366, 1, 12, 31, 0, 13);
    run(367, 1, 0, 0, 1, 1);
    run(511, 0, 0, 0, 1, 1);
    run(335, 1, 11, 30, 0, 12);

    // Leap flag changed after acceptance must not matter.
    launch(60, 1);
    dut_if.leapYear = 1'b0;
    finish(2, 29, 0, 3, 1);

    // Second start during CALC is ignored; exactly one done pulse.
    launch(100, 0);
    @(negedge clk);
    dut_if.start     = 1'b1;
    dut_if.dayOfYear = 9'd5;
    @(negedge clk);
    dut_if.start = 1'b0;
    finish(4, 10, 0, 5, 3);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (dut_if.done) pulses++;
    end
    chk("extra_done_pulses", pulses, 0);
    chk("hold_month_late", int'(dut_if.month), 4);
    chk("hold_day_late", int'(dut_if.dayOfMonth), 10);

    // Reset in the 5th CALC cycle aborts without a done pulse.
    launch(300, 0);
    pulses = 0;
    for (int c = 1; c < 5; c++) begin
      if (dut_if.done) pulses++;
      @(negedge clk);
    end
    if (dut_if.done) pulses++;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done_seen", pulses, 0);
    chk("abort_busy", int'(dut_if.busy), 0);
    chk("abort_done", int'(dut_if.done), 0);
    chk("abort_month", int'(dut_if.month), 0);
    chk("abort_day", int'(dut_if.dayOfMonth), 0);
    chk("abort_error", int'(dut_if.error), 0);
    reset = 1'b0;
    run(59, 0, 2, 28, 0, 3);

    // Start held high: back-to-back conversions, checked by the model.
    @(negedge clk);
    dut_if.start     = 1'b1;
    dut_if.dayOfYear = 9'd31;
    dut_if.leapYear  = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (dut_if.done) pulses++;
    end
    dut_if.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_start_pulses", pulses, 4);

    // Round trip from (month, day) through the day number and back.
    for (int lp = 0; lp < 2; lp++) begin
      for (int m = 1; m <= 12; m++) begin
        for (int d = 1; d <= mlen(m, bit'(lp)); d++) begin
          run(days_before(m, bit'(lp)) + d, bit'(lp), m, d, 0, m + 1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
